mdu_hilo: RTL and testbench
===========================

MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 START  input  1  operation request, sampled on each rising edge of CLK.
REQ-005 OP  input  3  opcode: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
REQ-006 A  input  32  operand rs (multiplicand, dividend, or MTHI/MTLO data).
REQ-007 B  input  32  operand rt (multiplier or divisor).
REQ-008 BUSY  output  1  high while a multi-cycle operation is in flight.
REQ-009 DONE  output  1  one-cycle pulse when HI/LO take a multi-cycle result.
REQ-010 HI  output  32  HI register.
REQ-011 LO  output  32  LO register.
REQ-012 HL_SEL  input  1  read select for MFHI/MFLO: 1 = HI, 0 = LO.
REQ-013 RD  output  32  combinational read, RD = HL_SEL ? HI : LO; feeds the register-file write-data port.

Function
REQ-014 FSM states: IDLE, MUL (iterative shift-add), DIV (restoring, one quotient bit per cycle), FIX (sign correction and commit).
REQ-015 A START is accepted only in IDLE with BUSY low; a START while BUSY is high SHALL be ignored with no state change.
REQ-016 MTHI/MTLO accepted at edge k: HI (or LO) = A after edge k; no BUSY, no DONE; the other register is unchanged.
REQ-017 MULT/MULTU/DIV/DIVU accepted at edge k: BUSY high after edges k..k+32; 32 iteration cycles, then FIX; HI/LO updated and DONE high for exactly one cycle after edge k+33, and BUSY low in that same cycle.
REQ-018 Operands SHALL be latched at acceptance; A/B changes during BUSY have no effect.
REQ-019 HI/LO SHALL hold their previous values throughout BUSY and change only at commit.
REQ-020 Signed ops: magnitudes are iterated and signs fixed in FIX; MULT gives {HI,LO} = 64-bit two's-complement product; MULTU gives the unsigned product.
REQ-021 DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-023 Divisor zero (DIV/DIVU): full 33-cycle latency; LO = 0xFFFFFFFF, HI = A.
REQ-024 A commit and a new START in the DONE cycle: the START SHALL be accepted, since BUSY is low.
REQ-025 RD reflects HI/LO combinationally, including the DONE cycle.

Reset
REQ-026 RST high at an edge: HI = 0, LO = 0, BUSY = 0, DONE = 0, FSM = IDLE.
REQ-027 RST SHALL take priority over START and SHALL abort any in-flight operation without committing.

Configuration
REQ-028 Macro MDU_MADD_EN defined: OP 110/111 perform {HI,LO} += signed/unsigned A*B (mod 2^64) with MULT timing.
REQ-029 Macro MDU_MADD_EN undefined: OP 110/111 SHALL be ignored (no BUSY, no state change), and no accumulate logic is built.

Verification
REQ-030 RST, then MTHI A=0x12345678 and HL_SEL=1 -> RD = 0x12345678 the next cycle; LO = 0.
REQ-031 MULT A=0xFFFFFFFE (-2), B=3 -> DONE 33 cycles after START; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU A=7, B=0 -> LO = 0xFFFFFFFF, HI = 7.
REQ-033 START MULTU during BUSY with different operands -> ignored; the first result commits unchanged.
REQ-034 RST pulsed at cycle 10 of DIVU -> HI = LO = 0, BUSY low, DONE never pulses.
REQ-035 With MDU_MADD_EN, HI:LO = 0:5, then MADDU A=2, B=3 -> LO = 11, HI = 0; without MDU_MADD_EN -> unchanged, BUSY stays low.

Source files
------------

// File: rtl/mdu_hilo.sv
// HI/LO multiply-divide unit: iterative shift-add multiply, restoring divide, MTHI/MTLO.
// Define MDU_MADD_EN to build the MADD/MADDU multiply-accumulate opcodes.
module mdu_hilo (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [2:0]  OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HL_SEL,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] RD
);
    localparam int unsigned W  = 32;
    localparam int unsigned W2 = 2 * W;
    localparam int unsigned CW = 5;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [W2-1:0]   p_q;        // mul: {acc, multiplier}; div: {remainder, quotient}
    logic [W-1:0]    m_q;        // multiplicand or divisor magnitude
    logic [W-1:0]    a_q;
    logic            neg_q, rneg_q, bzero_q, is_div_q;
`ifdef MDU_MADD_EN
    logic            madd_q;
`endif

    logic            op_mul_c, op_div_c, a_neg_c, b_neg_c;
    logic [W-1:0]    a_mag_c, b_mag_c;
    logic [W:0]      mul_sum_c, div_sh_c;
    logic            div_ge_c;
    logic [W-1:0]    div_rem_c;
    logic [W2-1:0]   mul_next_c, div_next_c, prod_c;
    logic [W-1:0]    quo_c, rem_c, commit_hi_c, commit_lo_c;

    // Opcode decode and operand magnitudes (bit 0 of OP clear = signed op)
    always_comb begin
        op_mul_c = (OP == OP_MULT) || (OP == OP_MULTU);
`ifdef MDU_MADD_EN
        op_mul_c = op_mul_c || (OP == OP_MADD) || (OP == OP_MADDU);
`endif
        op_div_c = (OP == OP_DIV) || (OP == OP_DIVU);
        a_neg_c  = ~OP[0] & A[W-1];
        b_neg_c  = ~OP[0] & B[W-1];
        a_mag_c  = a_neg_c ? (~A + W'(1)) : A;
        b_mag_c  = b_neg_c ? (~B + W'(1)) : B;
    end

    // One iteration of each algorithm
    always_comb begin
        mul_sum_c  = {1'b0, p_q[W2-1:W]} + (p_q[0] ? {1'b0, m_q} : (W+1)'(0));
        mul_next_c = {mul_sum_c, p_q[W-1:1]};
        div_sh_c   = {p_q[W2-1:W], p_q[W-1]};
        div_ge_c   = (div_sh_c >= {1'b0, m_q});
        div_rem_c  = div_ge_c ? W'(div_sh_c - {1'b0, m_q}) : W'(div_sh_c);
        div_next_c = {div_rem_c, p_q[W-2:0], div_ge_c};
    end

    // Sign correction and result selection for the commit cycle
    always_comb begin
        prod_c = neg_q ? (~p_q + W2'(1)) : p_q;
        quo_c  = neg_q ? (~p_q[W-1:0] + W'(1)) : p_q[W-1:0];
        rem_c  = rneg_q ? (~p_q[W2-1:W] + W'(1)) : p_q[W2-1:W];
        {commit_hi_c, commit_lo_c} = prod_c;
`ifdef MDU_MADD_EN
        if (madd_q) {commit_hi_c, commit_lo_c} = {HI, LO} + prod_c;
`endif
        if (is_div_q) begin
            commit_hi_c = bzero_q ? a_q : rem_c;
            commit_lo_c = bzero_q ? {W{1'b1}} : quo_c;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (START) begin
                if (op_mul_c)      state_d = S_MUL;
                else if (op_div_c) state_d = S_DIV;
            end
            S_MUL, S_DIV: if (cnt_q == CW'(W - 1)) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            HI <= '0; LO <= '0; BUSY <= 1'b0; DONE <= 1'b0;
            cnt_q <= '0; p_q <= '0; m_q <= '0; a_q <= '0;
            neg_q <= 1'b0; rneg_q <= 1'b0; bzero_q <= 1'b0; is_div_q <= 1'b0;
`ifdef MDU_MADD_EN
            madd_q <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state_q)
                S_IDLE: if (START) begin
                    if (OP == OP_MTHI) HI <= A;
                    if (OP == OP_MTLO) LO <= A;
                    if (op_mul_c || op_div_c) begin
                        BUSY     <= 1'b1;
                        cnt_q    <= '0;
                        a_q      <= A;
                        neg_q    <= a_neg_c ^ b_neg_c;
                        rneg_q   <= a_neg_c;
                        bzero_q  <= (B == '0);
                        is_div_q <= op_div_c;
                        p_q      <= {{W{1'b0}}, op_div_c ? a_mag_c : b_mag_c};
                        m_q      <= op_div_c ? b_mag_c : a_mag_c;
`ifdef MDU_MADD_EN
                        madd_q   <= OP[2];
`endif
                    end
                end
                S_MUL: begin
                    p_q   <= mul_next_c;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_DIV: begin
                    p_q   <= div_next_c;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIX: begin
                    HI   <= commit_hi_c;
                    LO   <= commit_lo_c;
                    BUSY <= 1'b0;
                    DONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign RD = HL_SEL ? HI : LO;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected HI:LO pushed at issue, popped on DONE.
module tb_mdu_hilo;
    logic        CLK, RST, START, HL_SEL, BUSY, DONE;
    logic [2:0]  OP;
    logic [31:0] A, B, HI, LO, RD;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [63:0] sb_q[$];
    logic [31:0] sh_hi, sh_lo;

    mdu_hilo dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
        .HL_SEL(HL_SEL), .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO), .RD(RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'b000: return sa * sb;
            3'b001: return ua * ub;
            3'b010: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'b011: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'b110: return hl + (sa * sb);
            3'b111: return hl + (ua * ub);
            default: return hl;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        START = 1'b1; OP = op; A = a; B = b;
        tick();
        START = 1'b0; A = $urandom; B = $urandom;
    endtask

    // Issue a multi-cycle op and check its whole life; optionally poke START while busy
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        logic [63:0] exp, pre;
        int n;
        exp = model(op, a, b, {sh_hi, sh_lo});
        sb_q.push_back(exp);
        {sh_hi, sh_lo} = exp;
        issue(op, a, b);
        pre = {HI, LO};
        check("busy_after_start", 64'(BUSY), 64'd1);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            if (inject && i == 5) begin
                START = 1'b1; OP = 3'b001; A = 32'h0000_1234; B = 32'h0000_5678;
            end
            tick();
            START = 1'b0;
            if (DONE) begin
                n = i;
                break;
            end
            check("hold_hilo", {HI, LO}, pre);
        end
        if (n == 0) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("latency", 64'(n), 64'd33);
            check("busy_low_at_done", 64'(BUSY), 64'd0);
            if (sb_q.size() == 0) begin
                check("sb_empty", 64'd0, 64'd1);
            end else begin
                check("hilo", {HI, LO}, sb_q.pop_front());
            end
            check("rd_lo_at_done", 64'(RD), 64'(LO));
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; OP = '0; A = '0; B = '0; HL_SEL = 1'b1;
        sh_hi = '0; sh_lo = '0;
        tick(); tick();
        RST = 1'b0;
        check("rst_hilo", {HI, LO}, 64'd0);
        check("rst_busy_done", {62'd0, BUSY, DONE}, 64'd0);

        issue(3'b100, 32'h1234_5678, 32'd0);
        sh_hi = 32'h1234_5678;
        check("mthi_rd", 64'(RD), 64'h1234_5678);
        check("mthi_lo", 64'(LO), 64'd0);
        check("mthi_busy_done", {62'd0, BUSY, DONE}, 64'd0);
        HL_SEL = 1'b0;
        issue(3'b101, 32'd5, 32'd0);
        sh_lo = 32'd5;
        check("mtlo_rd", 64'(RD), 64'd5);
        check("mtlo_hi", 64'(HI), 64'h1234_5678);

        run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'b011, 32'd7, 32'd0, 1'b0);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'b000, 32'd7, 32'hFFFF_FFF7, 1'b0);
        run_op(3'b010, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'd10, 1'b0);
        run_op(3'b000, 32'h0001_0000, 32'h7FFF_FFFF, 1'b1);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (k % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op(3'($urandom_range(0, 3)), ra, rb, 1'b0);
        end
        tick();
        check("done_one_cycle", 64'(DONE), 64'd0);

        // Reset in the middle of a divide aborts it without committing
        issue(3'b011, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sh_hi = '0; sh_lo = '0;
        check("abort_hilo", {HI, LO}, 64'd0);
        check("abort_busy", 64'(BUSY), 64'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("abort_no_done", 64'(DONE), 64'd0);
        end

        issue(3'b100, 32'd0, 32'd0);
        issue(3'b101, 32'd5, 32'd0);
        sh_hi = 32'd0; sh_lo = 32'd5;
`ifdef MDU_MADD_EN
        run_op(3'b111, 32'd2, 32'd3, 1'b0);
        check("maddu_lo", 64'(LO), 64'd11);
        run_op(3'b110, 32'hFFFF_FFFF, 32'd3, 1'b0);
        run_op(3'b110, 32'hFFFF_FFFF, 32'd9, 1'b0);
`else
        issue(3'b111, 32'd2, 32'd3);
        for (int i = 0; i < 4; i++) begin
            check("madd_off_busy", 64'(BUSY), 64'd0);
            tick();
        end
        check("madd_off_hilo", {HI, LO}, 64'd5);
        issue(3'b110, 32'd2, 32'd3);
        check("madd_off_busy2", 64'(BUSY), 64'd0);
`endif
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
